// File: rtl/design_top.sv
// Registered signed ALU: two IN_W-bit two's-complement operands, eight operations,
// result of width 2*IN_W-1 registered once. Asynchronous active-high reset (rstn).
module design_top #(
    parameter  int IN_W  = 5,
    localparam int OUT_W = 2*IN_W-1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic [2:0]       opcode,
    output logic [OUT_W-1:0] out_top
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_OR   = 3'd4,
        OP_AND  = 3'd5,
        OP_NAND = 3'd6,
        OP_NOR  = 3'd7
    } op_e;

    logic signed [OUT_W-1:0]  a_ext;
    logic signed [OUT_W-1:0]  b_ext;
    logic signed [OUT_W-1:0]  sum_res;
    logic signed [OUT_W-1:0]  diff_res;
    logic signed [2*IN_W-1:0] prod_full;
    logic signed [OUT_W-1:0]  prod_res;
    logic signed [OUT_W-1:0]  quot_res;
    logic        [IN_W-1:0]   or_bits;
    logic        [IN_W-1:0]   and_bits;
    logic signed [OUT_W-1:0]  alu_res;

    assign a_ext = OUT_W'($signed(in1));
    assign b_ext = OUT_W'($signed(in2));

    // Sign-extended operands keep add/sub exact: their range fits OUT_W.
    assign sum_res  = a_ext + b_ext;
    assign diff_res = a_ext - b_ext;

    // Only -min * -min exceeds OUT_W; dropping the top bit gives the wrap.
    assign prod_full = $signed(in1) * $signed(in2);
    assign prod_res  = prod_full[OUT_W-1:0];

    assign or_bits  = in1 | in2;
    assign and_bits = in1 & in2;

    // Restoring division on magnitudes, sign applied afterwards so the
    // quotient truncates toward zero. IN_W+1 bits hold the magnitude of -min.
    always_comb begin
        logic [IN_W:0]  num;
        logic [IN_W:0]  den;
        logic [IN_W:0]  rem;
        logic [IN_W:0]  quo;
        logic           neg;

        num = in1[IN_W-1] ? (IN_W+1)'(-a_ext) : (IN_W+1)'(a_ext);
        den = in2[IN_W-1] ? (IN_W+1)'(-b_ext) : (IN_W+1)'(b_ext);
        rem = '0;
        quo = '0;
        neg = in1[IN_W-1] ^ in2[IN_W-1];

        for (int i = IN_W; i >= 0; i--) begin
            rem = {rem[IN_W-1:0], num[i]};
            if (rem >= den) begin
                rem    = rem - den;
                quo[i] = 1'b1;
            end
        end

        if (den == '0) begin
            quot_res = '0;
        end else if (neg) begin
            quot_res = -$signed(OUT_W'(quo));
        end else begin
            quot_res = $signed(OUT_W'(quo));
        end
    end

    always_comb begin
        alu_res = '0;
        case (op_e'(opcode))
            OP_ADD:  alu_res = sum_res;
            OP_SUB:  alu_res = diff_res;
            OP_MUL:  alu_res = prod_res;
            OP_DIV:  alu_res = quot_res;
            OP_OR:   alu_res = OUT_W'($signed(or_bits));
            OP_AND:  alu_res = OUT_W'($signed(and_bits));
            OP_NAND: alu_res = OUT_W'($signed(~and_bits));
            OP_NOR:  alu_res = OUT_W'($signed(~or_bits));
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_top <= '0;
        end else begin
            out_top <= alu_res;
        end
    end

endmodule

// File: tb/tb_design_top.sv
// Bench for design_top: directed vector table, pipeline/reset sequences,
// and random vectors checked against an integer reference model.
module tb_design_top;

    logic       clk;
    logic       rstn;
    logic [4:0] in1;
    logic [4:0] in2;
    logic [2:0] opcode;
    logic [8:0] out_top;

    int n_vec;
    int n_err;
    int exp_q[$];

    typedef struct {
        int a;
        int b;
        int op;
        int exp;
    } vec_t;

    vec_t vecs[15];

    design_top dut (
        .clk     (clk),
        .rstn    (rstn),
        .in1     (in1),
        .in2     (in2),
        .opcode  (opcode),
        .out_top (out_top)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed reference written from the operation rules with plain integers.
    function automatic int to_s5(input int bits);
        int v;
        v = bits & 31;
        return (v >= 16) ? v - 32 : v;
    endfunction

    function automatic int wrap9(input int v);
        int m;
        m = (v + 256) % 512;
        if (m < 0) m = m + 512;
        return m - 256;
    endfunction

    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return wrap9(a * b);
            3: return (b == 0) ? 0 : a / b;
            4: return to_s5(a | b);
            5: return to_s5(a & b);
            6: return to_s5(~(a & b));
            default: return to_s5(~(a | b));
        endcase
    endfunction

    task automatic check(input string name, input int exp);
        int act;
        act = int'($signed(out_top));
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: out_top=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int op);
        in1    = a[4:0];
        in2    = b[4:0];
        opcode = op[2:0];
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs = '{
            '{  2,   3, 0,    5},
            '{ 14,   6, 1,    8},
            '{  2,   5, 2,   10},
            '{ 12,   4, 3,    3},
            '{ -7,   2, 3,   -3},
            '{-16, -16, 2, -256},
            '{-16, -16, 0,  -32},
            '{  5,   0, 3,    0},
            '{  6,  10, 4,   14},
            '{  2,   0, 5,    0},
            '{  8,   5, 6,   -1},
            '{  0,   0, 7,   -1},
            '{ -1,  -1, 5,   -1},
            '{  1,   2, 4,    3},
            '{-16,  -1, 3,   16}
        };

        // Reset from time zero, checked before any clock edge.
        rstn = 1'b1;
        drive(7, 7, 0);
        #1;
        check("reset_initial", 0);
        @(negedge clk);
        check("reset_held", 0);
        rstn = 1'b0;

        // Directed table, one vector per cycle.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            @(posedge clk);
            #1;
            check($sformatf("table[%0d]", i), vecs[i].exp);
            @(negedge clk);
        end

        // Asynchronous reset between edges while out_top is nonzero (16).
        #2;
        rstn = 1'b1;
        #1;
        check("reset_async", 0);
        @(negedge clk);
        rstn = 1'b0;

        // Pipeline: new inputs every edge through all opcodes.
        for (int i = 0; i < 16; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 31)) - 16;
            b = int'($urandom_range(0, 31)) - 16;
            drive(a, b, i % 8);
            exp_q.push_back(ref_alu(a, b, i % 8));
            @(posedge clk);
            #1;
            check($sformatf("pipe[%0d]", i), exp_q.pop_front());
            @(negedge clk);
        end

        // Reset while 3*4 is pending; 12 must never reach out_top.
        drive(3, 4, 2);
        #2;
        rstn = 1'b1;
        #1;
        check("midreset_async", 0);
        @(posedge clk);
        #1;
        check("midreset_edge", 0);
        @(negedge clk);
        rstn = 1'b0;
        drive(7, 2, 1);
        @(posedge clk);
        #1;
        check("midreset_release", 5);
        @(negedge clk);

        // Random vectors against the reference model.
        for (int i = 0; i < 1000; i++) begin
            int a;
            int b;
            int op;
            a  = int'($urandom_range(0, 31)) - 16;
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31)) - 16;
            op = int'($urandom_range(0, 7));
            drive(a, b, op);
            exp_q.push_back(ref_alu(a, b, op));
            @(posedge clk);
            #1;
            check($sformatf("rand[%0d] %0d op%0d %0d", i, a, op, b), exp_q.pop_front());
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
